data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the core's memory interface. Accepts one word-aligned read or write
//  request at a time, applies byte-lane frame masks on writes and returns the full word on
//  reads after a fixed, parameterised latency. Drives the shared tri-state data bus only
//  while returning read data. Serves as the data memory in simulation and FPGA builds.
// PARAMETERS
//  DEPTH_WORDS   1024          storage depth in 32-bit words (power of two, >= 2)
//  BASE_ADDRESS  32'h0000_0000 byte address of word 0 (4-byte aligned)
//  LATENCY       1             cycles from request acceptance to ready (1..15)
// PORTS
//  clk                          in     1   clock, rising edge
//  reset                        in     1   asynchronous, active-high
//  memory_interface_enable      in     1   1 = request valid; held until ready
//  memory_interface_state       in     1   0 = READ, 1 = WRITE
//  memory_interface_address     in     32  byte address; bits [1:0] ignored
//  memory_interface_frame_mask  in     4   lane enables: [3]=data[7:0] [2]=[15:8] [1]=[23:16] [0]=[31:24]
//  memory_interface_data        inout  32  write data in; read data out during RESPOND only
//  memory_interface_ready       out    1   one-cycle pulse: request complete
//  memory_interface_error       out    1   pulses with ready when address out of range
// BEHAVIOUR
//  - Reset: FSM=IDLE, latency counter=0, ready=0, error=0, data bus 'z. Storage contents
//    are NOT cleared. Reset mid-transaction aborts it; a pending write is never committed.
//  - In range: BASE_ADDRESS <= address < BASE_ADDRESS + 4*DEPTH_WORDS; word index =
//    (address - BASE_ADDRESS) >> 2, index width clog2(DEPTH_WORDS).
//  - FSM IDLE -> WAIT -> RESPOND -> IDLE:
//    IDLE: at an edge with enable=1, capture address, state and mask; counter = LATENCY-1;
//      go to RESPOND if LATENCY=1, else WAIT.
//    WAIT: decrement counter each edge; at counter 1 go to RESPOND. enable=0 at an edge in
//      WAIT aborts to IDLE: no write, no ready.
//    RESPOND: ready=1 for exactly this cycle, error=1 if address out of range; next edge
//      returns to IDLE unconditionally.
//  - Ready is high during cycle N+LATENCY, where N is the cycle in which the request was
//    accepted. Minimum issue interval is LATENCY+1 cycles. A request still present in the
//    IDLE cycle after RESPOND is treated as a new request.
//  - Write: at the edge that enters RESPOND, in-range only, each lane whose mask bit is 1
//    takes the matching byte of memory_interface_data sampled at that edge. Other lanes keep
//    their value. Mask 4'b0000 completes with ready and no change. Mask bits that are x/z
//    are treated as 0.
//  - Read: the word is registered at the edge that enters RESPOND. The full 32-bit word is
//    driven during RESPOND regardless of mask; lane selection and extension belong to the
//    initiator. Out-of-range reads drive 32'h0000_0000. Outside RESPOND-of-a-read the bus is 'z.
//  - Out-of-range writes are discarded; ready and error still pulse.
//  - No bus contention: the bus is never driven while the captured state is WRITE.
// TESTING
//  1 Reset, then SW addr 0x10 data 0xDEADBEEF mask 1111, then LW 0x10 -> bus 0xDEADBEEF
//    in the ready cycle; ready exactly LATENCY cycles after acceptance (check LATENCY=1 and 4).
//  2 Over 0x11223344 at 0x20: SB mask 1000 data 0x000000AB, then mask 0001 data 0xCD000000
//    -> LW 0x20 returns 0xCD2233AB.
//  3 SH mask 1100 data 0x0000BEEF at 0x24 over 0 -> read 0x0000BEEF; then mask 0011 data
//    0xCAFE0000 -> read 0xCAFEBEEF.
//  4 Write or read at BASE_ADDRESS + 4*DEPTH_WORDS -> ready and error pulse together, read
//    bus 0x0, no storage change (verify a neighbouring word).
//  5 LATENCY=4: drop enable in the 2nd WAIT cycle of a write -> no ready; target word unchanged;
//    FSM back in IDLE and the next request completes normally.
//  6 Assert reset in the WAIT cycle of a write -> ready=0, bus 'z, FSM IDLE; word unchanged;
//    previously written data survives reset.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-wide data memory answering one read/write request at a time after LATENCY cycles.
// Writes honour byte-lane masks; read data is driven onto the shared bus only while responding.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned LATENCY      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  inout  wire  [31:0] memory_interface_data,
  output logic        memory_interface_ready,
  output logic        memory_interface_error
);

  localparam int unsigned IDXW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [3:0]      mask_q;
  logic [IDXW-1:0] idx_q;
  logic            in_range_q;
  logic [31:0]     rdata_q;

  logic            accept, commit;
  logic [31:0]     req_off;
  logic            req_write, req_in_range;
  logic [3:0]      req_mask;
  logic [IDXW-1:0] req_idx;
  logic            bus_oe;

  logic [31:0] mem [DEPTH_WORDS];

  // Live inputs in IDLE (LATENCY=1 commits at the accepting edge), captured copy otherwise.
  always_comb begin
    req_off = memory_interface_address - BASE_ADDRESS;
    if (state_q == S_IDLE) begin
      req_write    = memory_interface_state;
      req_mask     = memory_interface_frame_mask;
      req_in_range = (memory_interface_address >= BASE_ADDRESS) && ({1'b0, req_off} < SPAN);
      req_idx      = req_off[IDXW+1:2];
    end else begin
      req_write    = write_q;
      req_mask     = mask_q;
      req_in_range = in_range_q;
      req_idx      = idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memory_interface_enable) begin
          accept = 1'b1;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = S_RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!memory_interface_enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESPOND;
          commit  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      mask_q     <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q    <= req_write;
        mask_q     <= req_mask;
        idx_q      <= req_idx;
        in_range_q <= req_in_range;
      end
      if (commit) begin
        rdata_q <= req_in_range ? mem[req_idx] : 32'h0000_0000;
      end
    end
  end

  // Storage is deliberately not reset; mask bit b selects byte lane 3-b.
  always_ff @(posedge clk) begin
    if (!reset && commit && req_write && req_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b] == 1'b1) begin
          mem[req_idx][8*(3-b) +: 8] <= memory_interface_data[8*(3-b) +: 8];
        end
      end
    end
  end

  always_comb begin
    memory_interface_ready = (state_q == S_RESPOND);
    memory_interface_error = (state_q == S_RESPOND) && !in_range_q;
    bus_oe                 = (state_q == S_RESPOND) && !write_q;
  end

  assign memory_interface_data = bus_oe ? rdata_q : 32'bz;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at LATENCY=1 (s=0), one at LATENCY=4 (s=1).
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic        st;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] tb_dat;
  logic        tb_oe;
  wire  [31:0] bus0, bus1;
  logic [1:0]  rdy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign bus0 = tb_oe ? tb_dat : 32'bz;
  assign bus1 = tb_oe ? tb_dat : 32'bz;

  data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDRESS(32'h0), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .memory_interface_enable(en[0]), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_data(bus0), .memory_interface_ready(rdy[0]), .memory_interface_error(err[0]));

  data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDRESS(32'h0), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .memory_interface_enable(en[1]), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_data(bus1), .memory_interface_ready(rdy[1]), .memory_interface_error(err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 1) ? 4 : 1;
  endfunction

  function automatic logic oe_of(input int s);
    return (s == 1) ? dut4.bus_oe : dut1.bus_oe;
  endfunction

  // One handshake; returns bus value, error and cycles from acceptance to ready (sampled at negedge).
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
    logic got;
    @(negedge clk);
    en[s] = 1'b1; st = wr; addr = a; mask = m; tb_dat = wd; tb_oe = wr;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rdy[s]) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 32'(got), 32'd1);
    rd = (s == 1) ? bus1 : bus0;
    e  = err[s];
    chk("bus_oe_in_respond", 32'(oe_of(s)), 32'(!wr));
    en[s] = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic do_wr(input int s, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       input logic exp_err);
    logic [31:0] rd; logic e; int lat;
    xfer(s, 1'b1, a, m, d, rd, e, lat);
    chk("wr_latency", 32'(lat), 32'(lat_of(s)));
    chk("wr_error", 32'(e), 32'(exp_err));
  endtask

  task automatic do_rd(input int s, input string tag, input logic [31:0] a, input logic [31:0] exp,
                       input logic exp_err);
    logic [31:0] rd; logic e; int lat;
    xfer(s, 1'b0, a, 4'b0000, 32'h0, rd, e, lat);
    chk(tag, rd, exp);
    chk("rd_latency", 32'(lat), 32'(lat_of(s)));
    chk("rd_error", 32'(e), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1; en = 2'b00; st = 1'b0; addr = '0; mask = '0; tb_dat = '0; tb_oe = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_oe", {30'd0, dut4.bus_oe, dut1.bus_oe}, 32'd0);
    chk("rst_state", {30'd0, dut4.state_q}, 32'd0);
    reset = 1'b0;

    // Full-word write then read, both latencies; ready is a single-cycle pulse.
    for (int s = 0; s < 2; s++) begin
      do_wr(s, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
      do_rd(s, "lw_deadbeef", 32'h10, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk("ready_one_cycle", 32'(rdy[s]), 32'd0);
      chk("bus_released", 32'(oe_of(s)), 32'd0);
    end

    // Byte lanes at LATENCY=4.
    do_wr(1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
    do_wr(1, 32'h20, 4'b1000, 32'h000000AB, 1'b0);
    do_wr(1, 32'h20, 4'b0001, 32'hCD000000, 1'b0);
    do_rd(1, "sb_lanes", 32'h20, 32'hCD2233AB, 1'b0);

    // Half-word lanes and empty mask at LATENCY=1; low address bits are ignored.
    do_wr(0, 32'h24, 4'b1111, 32'h00000000, 1'b0);
    do_wr(0, 32'h24, 4'b1100, 32'h0000BEEF, 1'b0);
    do_rd(0, "sh_low", 32'h24, 32'h0000BEEF, 1'b0);
    do_wr(0, 32'h26, 4'b0011, 32'hCAFE0000, 1'b0);
    do_rd(0, "sh_high", 32'h24, 32'hCAFEBEEF, 1'b0);
    do_wr(0, 32'h24, 4'b0000, 32'hFFFFFFFF, 1'b0);
    do_rd(0, "mask_none", 32'h27, 32'hCAFEBEEF, 1'b0);

    // First out-of-range address: error with ready, nothing stored (index would alias word 0).
    do_wr(1, 32'h0, 4'b1111, 32'h0A0B0C0D, 1'b0);
    do_wr(1, 32'hFFC, 4'b1111, 32'h600DF00D, 1'b0);
    do_wr(1, 32'h1000, 4'b1111, 32'hBAD0BAD0, 1'b1);
    do_rd(1, "oob_read_zero", 32'h1000, 32'h0, 1'b1);
    do_rd(1, "oob_alias_word0", 32'h0, 32'h0A0B0C0D, 1'b0);
    do_rd(1, "oob_last_word", 32'hFFC, 32'h600DF00D, 1'b0);
    do_wr(0, 32'h1000, 4'b1111, 32'hBAD0BAD0, 1'b1);
    do_rd(0, "oob_l1_neighbour", 32'h10, 32'hDEADBEEF, 1'b0);

    // Enable dropped in the second WAIT cycle aborts the write.
    do_wr(1, 32'h30, 4'b1111, 32'h12345678, 1'b0);
    begin
      int seen = 0;
      @(negedge clk);
      en[1] = 1'b1; st = 1'b1; addr = 32'h30; mask = 4'b1111; tb_dat = 32'hFFFFFFFF; tb_oe = 1'b1;
      @(negedge clk);
      seen += int'(rdy[1]);
      @(negedge clk);
      en[1] = 1'b0; tb_oe = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen += int'(rdy[1]);
      end
      chk("abort_no_ready", 32'(seen), 32'd0);
      chk("abort_state_idle", {30'd0, dut4.state_q}, 32'd0);
    end
    do_rd(1, "abort_word_kept", 32'h30, 32'h12345678, 1'b0);
    do_wr(1, 32'h34, 4'b1111, 32'h87654321, 1'b0);
    do_rd(1, "after_abort", 32'h34, 32'h87654321, 1'b0);

    // Reset during WAIT: nothing committed, stored data survives.
    do_wr(1, 32'h40, 4'b1111, 32'h55AA55AA, 1'b0);
    @(negedge clk);
    en[1] = 1'b1; st = 1'b1; addr = 32'h40; mask = 4'b1111; tb_dat = 32'h00000000; tb_oe = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wait_ready", 32'(rdy[1]), 32'd0);
    chk("rst_wait_oe", 32'(dut4.bus_oe), 32'd0);
    chk("rst_wait_state", {30'd0, dut4.state_q}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; en[1] = 1'b0; tb_oe = 1'b0;
    do_rd(1, "rst_word_kept", 32'h40, 32'h55AA55AA, 1'b0);
    do_rd(1, "rst_old_data", 32'h10, 32'hDEADBEEF, 1'b0);
    do_rd(0, "rst_old_data_l1", 32'h24, 32'hCAFEBEEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
